// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: a frame-latched hex value, a guard gap
// before every digit slot, 16-tick brightness PWM and leading-zero blanking.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 2,
  parameter int GUARD_CYCLES   = 64,
  parameter int TICK_CYCLES    = 256,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [3:0]              brightness,
  input  logic                    lz_blank,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_start
);

  localparam int CMAX = (GUARD_CYCLES > TICK_CYCLES) ? GUARD_CYCLES : TICK_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int DW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [0:0] ST_GUARD = 1'b0;
  localparam logic [0:0] ST_ON    = 1'b1;

  // XOR masks: an "off" pattern in pin polarity, also used to flip active-high data
  localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

  logic [0:0]              state;
  logic [CW-1:0]           cyc_cnt;
  logic [3:0]              tick_idx;
  logic [DW-1:0]           dig_idx;
  logic [4*NUM_DIGITS-1:0] shadow;

  logic                    frame_latch;
  logic                    lit;
  logic [3:0]              cur_nib;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_above;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F; 4'h1: s = 7'h06; 4'h2: s = 7'h5B; 4'h3: s = 7'h4F;
      4'h4: s = 7'h66; 4'h5: s = 7'h6D; 4'h6: s = 7'h7D; 4'h7: s = 7'h07;
      4'h8: s = 7'h7F; 4'h9: s = 7'h6F; 4'hA: s = 7'h77; 4'hB: s = 7'h7C;
      4'hC: s = 7'h39; 4'hD: s = 7'h5E; 4'hE: s = 7'h79; default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign frame_latch = (state == ST_GUARD) && (dig_idx == '0) && (cyc_cnt == '0);
  assign cur_nib     = shadow[int'(dig_idx)*4 +: 4];

  // A digit above 0 is blank only if it and every more-significant nibble are zero
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS-1; i > 0; i--) begin
      zero_above = zero_above && (shadow[i*4 +: 4] == 4'h0);
      blank[i]   = lz_blank && zero_above;
    end
  end

  assign lit = (state == ST_ON) && (tick_idx < brightness) && !blank[dig_idx];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_GUARD;
      cyc_cnt  <= '0;
      tick_idx <= '0;
      dig_idx  <= '0;
      shadow   <= '0;
    end else begin
      case (state)
        ST_GUARD: begin
          if (cyc_cnt == CW'(GUARD_CYCLES-1)) begin
            state    <= ST_ON;
            cyc_cnt  <= '0;
            tick_idx <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        default: begin
          if (cyc_cnt == CW'(TICK_CYCLES-1)) begin
            cyc_cnt  <= '0;
            tick_idx <= tick_idx + 1'b1;
            if (tick_idx == 4'hF) begin
              state   <= ST_GUARD;
              dig_idx <= (dig_idx == DW'(NUM_DIGITS-1)) ? '0 : dig_idx + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
      endcase
      if (frame_latch) shadow <= value;
    end
  end

  // Registered pin stage; async reset forces everything dark mid-slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg         <= SEG_OFF;
      digit_en    <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      seg         <= lit ? (hex_decode(cur_nib) ^ SEG_OFF) : SEG_OFF;
      digit_en    <= lit ? ((NUM_DIGITS'(1) << dig_idx) ^ DIG_OFF) : DIG_OFF;
      frame_start <= frame_latch;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Frame-level scoreboard bench for seg_scan_ctrl (2 digits, guard 2, tick 1).
module tb_seg_scan_ctrl;

  localparam int FRAME = 36;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] value;
  logic [3:0] brightness;
  logic       lz_blank;
  logic [6:0] seg;
  logic [1:0] digit_en;
  logic       frame_start;

  seg_scan_ctrl #(
    .NUM_DIGITS(2), .GUARD_CYCLES(2), .TICK_CYCLES(1),
    .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .reset(reset), .value(value), .brightness(brightness),
    .lz_blank(lz_blank), .seg(seg), .digit_en(digit_en), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         fno;
    int         c0;
    logic [6:0] s0;
    int         c1;
    logic [6:0] s1;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   frame_no = 0;

  logic [6:0] dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input int fno, input logic [7:0] v, input int b, input logic lz);
    exp_t e;
    e.fno = fno;
    e.c0  = b;
    e.s0  = ~dec_tbl[v[3:0]];
    e.c1  = (lz && v[7:4] == 4'h0) ? 0 : b;
    e.s1  = ~dec_tbl[v[7:4]];
    exp_q.push_back(e);
  endtask

  // Per-frame observation state
  bit         have_prev = 0;
  int         per, c0, c1, bad_idle, unstable, onehot_viol, gap_viol;
  int         last_act = -1, off_run = 0;
  logic [6:0] s0, s1;

  task automatic finish_frame(input int n);
    exp_t e;
    chk("period", per, FRAME);
    chk("idle_seg", bad_idle, 0);
    chk("seg_stable", unstable, 0);
    chk("onehot0", onehot_viol, 0);
    chk("guard_gap", gap_viol, 0);
    while (exp_q.size() > 0 && exp_q[0].fno < n) begin
      e = exp_q.pop_front();
      chk("missed_frame", n, e.fno);
    end
    if (exp_q.size() > 0 && exp_q[0].fno == n) begin
      e = exp_q.pop_front();
      chk("lit0", c0, e.c0);
      chk("lit1", c1, e.c1);
      if (e.c0 > 0) chk("seg0", s0, e.s0);
      if (e.c1 > 0) chk("seg1", s1, e.s1);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      have_prev = 0;
      last_act  = -1;
      off_run   = 0;
    end else begin
      if (frame_start) begin
        if (have_prev) finish_frame(frame_no);
        frame_no++;
        have_prev = 1;
        per = 0; c0 = 0; c1 = 0; bad_idle = 0; unstable = 0; onehot_viol = 0; gap_viol = 0;
      end
      per++;
      case (digit_en)
        2'b00: begin
          if (seg !== 7'h7F) bad_idle++;
          off_run++;
        end
        2'b01, 2'b10: begin
          automatic int d = (digit_en == 2'b01) ? 0 : 1;
          if (last_act != -1 && last_act != d && off_run < 2) gap_viol++;
          if (d == 0) begin
            if (c0 > 0 && seg !== s0) unstable++;
            c0++; s0 = seg;
          end else begin
            if (c1 > 0 && seg !== s1) unstable++;
            c1++; s1 = seg;
          end
          last_act = d;
          off_run  = 0;
        end
        default: onehot_viol++;
      endcase
    end
  end

  task automatic wait_fs();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_start && k < 200);
    if (!frame_start) chk("fs_timeout", 0, 1);
    #1;
  endtask

  // Apply a config at a frame start; the following frame is fully governed by it
  task automatic run_cfg(input logic [7:0] v, input logic [3:0] b, input logic lz);
    wait_fs();
    value = v; brightness = b; lz_blank = lz;
    push_exp(frame_no + 1, v, b, lz);
    wait_fs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; value = 8'h3A; brightness = 4'd15; lz_blank = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dig", digit_en, 2'b00);
    chk("rst_fs", frame_start, 1'b0);
    push_exp(1, 8'h3A, 15, 1'b0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("fs_after_reset", frame_start, 1'b1);
    wait_fs();
    push_exp(frame_no, 8'h3A, 15, 1'b0);

    run_cfg(8'h3A, 4'd0, 1'b0);
    run_cfg(8'h3A, 4'd1, 1'b0);
    run_cfg(8'hC7, 4'd8, 1'b0);

    // Mid-frame value change: the current frame keeps 12, the next shows 34
    run_cfg(8'h12, 4'd15, 1'b0);
    repeat (18) @(negedge clk);
    value = 8'h34;
    push_exp(frame_no + 1, 8'h34, 15, 1'b0);
    wait_fs();
    wait_fs();

    run_cfg(8'h05, 4'd15, 1'b1);
    run_cfg(8'h00, 4'd15, 1'b1);
    run_cfg(8'hF0, 4'd15, 1'b1);
    run_cfg(8'h05, 4'd15, 1'b0);
    wait_fs();

    // Reset during digit 0's on-phase, then restart at digit 0
    repeat (5) @(negedge clk);
    chk("pre_reset_lit", digit_en, 2'b01);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_seg", seg, 7'h7F);
    chk("async_dig", digit_en, 2'b00);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    chk("fs_restart", frame_start, 1'b1);
    #1;
    push_exp(frame_no, 8'h05, 15, 1'b0);
    wait_fs();
    wait_fs();

    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
